// File: rtl/mnacidpro_ctrl_sequencer_pkg.sv
// mnacidpro_ctrl_pkg: shared opcodes, states, pump patterns and size defaults
package mnacidpro_ctrl_pkg;
    localparam int CTRL_SIZE_DEF  = 13;
    localparam int PUMP_SIZE_DEF  = 3;
    localparam int FLUSH_SIZE_DEF = 16;
    localparam int CNT_W_DEF      = 16;
    localparam int TICK_DIV_DEF   = 1000;

    typedef enum logic [1:0] {
        OP_SET_VALVES = 2'd0,
        OP_PUMP       = 2'd1,
        OP_FLUSH      = 2'd2,
        OP_WAIT       = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] PUMP_PH0 = 3'b110;
    localparam logic [2:0] PUMP_PH1 = 3'b101;
    localparam logic [2:0] PUMP_PH2 = 3'b011;

    // Reverse direction walks the same three patterns backwards.
    function automatic logic [2:0] pump_pattern(input logic [1:0] phase, input logic rev);
        logic [1:0] idx;
        idx = rev ? 2'd2 - phase : phase;
        return idx == 2'd0 ? PUMP_PH0 : idx == 2'd1 ? PUMP_PH1 : PUMP_PH2;
    endfunction
endpackage

// File: rtl/mnacidpro_ctrl_sequencer_if.sv
// mnacidpro_ctrl_sequencer_if: command handshake bus plus abort
interface mnacidpro_ctrl_sequencer_if #(
    parameter int FLUSH_SIZE = mnacidpro_ctrl_pkg::FLUSH_SIZE_DEF,
    parameter int CNT_W      = mnacidpro_ctrl_pkg::CNT_W_DEF
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [FLUSH_SIZE-1:0] cmd_mask;
    logic [CNT_W-1:0]      cmd_count;
    logic                  abort;

    modport master (output cmd_valid, cmd_op, cmd_mask, cmd_count, abort, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_mask, cmd_count, abort, output cmd_ready);
endinterface

// File: rtl/mnacidpro_ctrl_sequencer_tick_prescaler.sv
// ctrl_tick_prescaler: counts 0..TICK_DIV-1 and pulses tick on the wrap cycle
module ctrl_tick_prescaler #(
    parameter int TICK_DIV = mnacidpro_ctrl_pkg::TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == LAST;

    // Restart wins over wrap so the first tick of a command is a full period.
    always_comb begin
        cnt_d = restart ? '0 : tick ? '0 : cnt_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mnacidpro_ctrl_sequencer.sv
// mnacidpro_ctrl_sequencer: tick-timed valve, pump, flush and wait command sequencer
module mnacidpro_ctrl_sequencer
    import mnacidpro_ctrl_pkg::*;
#(
    parameter int CTRL_SIZE  = CTRL_SIZE_DEF,
    parameter int PUMP_SIZE  = PUMP_SIZE_DEF,
    parameter int FLUSH_SIZE = FLUSH_SIZE_DEF,
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    mnacidpro_ctrl_sequencer_if.slave cmd,
    output logic [CTRL_SIZE-1:0]  ctrl,
    output logic [PUMP_SIZE-1:0]  pump,
    output logic [FLUSH_SIZE-1:0] flush,
    output logic                  busy,
    output logic                  done
);
    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic                  dir_q, dir_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            phase_q, phase_d;
    logic [CTRL_SIZE-1:0]  ctrl_q, ctrl_d;
    logic [PUMP_SIZE-1:0]  pump_q, pump_d;
    logic [FLUSH_SIZE-1:0] flush_q, flush_d;

    logic             ready, accept, tick, last;
    logic [CNT_W:0]   cnt_inc;
    op_e              in_op;

    assign ready         = state_q == ST_IDLE && !cmd.abort;
    assign accept        = ready && cmd.cmd_valid;
    assign cmd.cmd_ready = ready;
    assign in_op         = op_e'(cmd.cmd_op);
    // One extra bit keeps the count compare exact at the maximum count.
    assign cnt_inc       = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign last          = cnt_inc == {1'b0, count_q};

    assign ctrl  = ctrl_q;
    assign pump  = pump_q;
    assign flush = flush_q;
    assign busy  = state_q == ST_RUN;
    assign done  = state_q == ST_DONE;

    ctrl_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    // Next-state and output-register logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dir_d   = dir_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        ctrl_d  = ctrl_q;
        pump_d  = pump_q;
        flush_d = flush_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = in_op;
                    dir_d   = cmd.cmd_mask[0];
                    count_d = cmd.cmd_count;
                    cnt_d   = '0;
                    phase_d = 2'd0;
                    if (in_op == OP_SET_VALVES) begin
                        ctrl_d  = cmd.cmd_mask[CTRL_SIZE-1:0];
                        state_d = ST_DONE;
                    end else if (cmd.cmd_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        if (in_op == OP_PUMP)  pump_d  = PUMP_SIZE'(pump_pattern(2'd0, cmd.cmd_mask[0]));
                        if (in_op == OP_FLUSH) flush_d = cmd.cmd_mask;
                    end
                end
            end
            ST_RUN: begin
                if (cmd.abort) begin
                    state_d = ST_DONE;
                    pump_d  = '0;
                    flush_d = '0;
                end else if (tick) begin
                    if (op_q == OP_PUMP) begin
                        phase_d = phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1;
                        if (phase_q == 2'd2) cnt_d = cnt_inc[CNT_W-1:0];
                        if (phase_q == 2'd2 && last) begin
                            state_d = ST_DONE;
                            pump_d  = '0;
                        end else begin
                            pump_d = PUMP_SIZE'(pump_pattern(phase_d, dir_q));
                        end
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                        if (last) begin
                            state_d = ST_DONE;
                            flush_d = '0;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_SET_VALVES;
            dir_q   <= 1'b0;
            count_q <= '0;
            cnt_q   <= '0;
            phase_q <= 2'd0;
            ctrl_q  <= '0;
            pump_q  <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            ctrl_q  <= ctrl_d;
            pump_q  <= pump_d;
            flush_q <= flush_d;
        end
    end
endmodule

// File: doc/mnacidpro_ctrl_sequencer.md
# mnacidpro_ctrl_sequencer

Off-chip actuation sequencer for the mnacidpro microfluidic device. It accepts valve, pump, flush and wait commands over a valid/ready interface. It drives the device's 13 control-valve lines, 3 peristaltic pump lines and 16 flush lines with deterministic, tick-timed patterns. It sits between the host command source and the solenoid drivers that feed the device's ctrl, pump and flush holes.

## Interface
- CTRL_SIZE, 13, number of control-valve lines
- PUMP_SIZE, 3, number of pump lines; fixed at 3 for the three-phase pattern
- FLUSH_SIZE, 16, number of flush lines; also the width of cmd_mask
- TICK_DIV, 1000, clock cycles per actuation tick; must be ≥ 2
- CNT_W, 16, width of cmd_count and the internal tick counter
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  opcode: 0 SET_VALVES, 1 PUMP, 2 FLUSH, 3 WAIT
- cmd_mask  in  FLUSH_SIZE  valve mask, flush mask, or pump direction (bit 0)
- cmd_count  in  CNT_W  strokes for PUMP; ticks for FLUSH and WAIT
- abort  in  1  cancel the running command
- ctrl  out  CTRL_SIZE  valve drive; 1 = energized
- pump  out  PUMP_SIZE  pump valve drive; 1 = closed
- flush  out  FLUSH_SIZE  flush drive
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a command completes or is aborted

## Operation
- States are IDLE, RUN and DONE.
- cmd_ready = (state==IDLE) && !abort. A command is accepted on the edge where cmd_valid && cmd_ready.
- Accepted commands are captured into registers. The tick prescaler restarts at 0 on accept.
- SET_VALVES
  - ctrl <= cmd_mask[CTRL_SIZE-1:0] on the accept edge.
  - Goes directly to DONE.
  - ctrl holds its value until the next SET_VALVES or reset; abort does not change it.
- PUMP, count N
  - Runs 3N ticks, stepping one phase per tick.
  - Forward order (mask[0]=0): 110, 101, 011, repeating.
  - Reverse order (mask[0]=1): 011, 101, 110, repeating.
  - Phase 0 appears on the cycle after accept.
- FLUSH, count N
  - flush = cmd_mask for N ticks.
- WAIT, count N
  - Holds all outputs for N ticks.
- When count is 0 for PUMP, FLUSH or WAIT, the sequencer goes to DONE immediately and no outputs change.
- On leaving RUN, pump and flush return to 0 in the DONE cycle.
- DONE lasts exactly one cycle with done=1, then the state returns to IDLE.
- abort in RUN: next state is DONE, pump and flush return to 0, done pulses. abort in IDLE or DONE has no effect except that it holds cmd_ready low.
- Reset values: state IDLE, ctrl 0, pump 0, flush 0, busy 0, done 0. cmd_ready is 1 once rst is released.
- Reset asserted mid-command clears all state immediately (asynchronously). The command is lost.

## Timing
- Tick length is TICK_DIV cycles. Tick k ends when the prescaler wraps for the (k+1)th time.
- A command with count N completes RUN after N·TICK_DIV cycles for FLUSH/WAIT and 3N·TICK_DIV cycles for PUMP. done is asserted on the following cycle.
- SET_VALVES: accepted at edge t, then ctrl updates and done=1 at t+1, then cmd_ready=1 at t+2. Minimum command spacing is 2 cycles.
- Back-to-back commands: the earliest accept is the cycle after DONE.
- cmd_count is compared against the tick counter at full CNT_W width. The maximum count is 2^CNT_W−1, with no wrap.
- The pump phase index wraps 2→0. The stroke counter increments on each wrap.

## Structure
- Shared package mnacidpro_ctrl_pkg holds:
  - opcode constants
  - the state enum
  - the pump phase pattern constants (110, 101, 011)
  - the default CTRL/PUMP/FLUSH size localparams shared with the device wrapper
- One sub-module, ctrl_tick_prescaler: counter from 0 to TICK_DIV−1 with a synchronous restart, producing a one-cycle tick pulse on wrap.

## Test plan
All scenarios run with TICK_DIV=4.
- Reset, then SET_VALVES mask 0x1A5B → ctrl=0x1A5B at t+1, done at t+1, cmd_ready low at t+1 and high at t+2.
- PUMP forward, count 2 → pump sequence 110,101,011,110,101,011, each held 4 cycles; busy high for 24 cycles; then pump=000 and a done pulse.
- PUMP reverse, count 1 → pump 011,101,110; FLUSH count 0 → done the cycle after accept with flush remaining 0.
- FLUSH mask 0xFFFF, count 3 → flush=0xFFFF for 12 cycles; abort asserted at cycle 5 → flush=0 and done on the next cycle; ctrl unchanged.
- abort and cmd_valid asserted together in IDLE → command not accepted, no done pulse. rst asserted mid-PUMP → all outputs 0 immediately; after release, cmd_ready=1.
